// File: rtl/csr_unit_pkg.sv
// Shared types and CSR addresses for the machine-mode CSR unit.
package csr_unit_pkg;

    typedef enum logic [1:0] {
        CSR_READ = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_mode_e;

    typedef struct packed {
        logic        valid;
        logic        use_imm;
        csr_mode_e   csr_mode;
        logic [11:0] csr_target;
    } csr_req_t;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

endpackage

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap entry / MRET sequencing and fetch redirect.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  csr_req_t    csr_req,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    output logic [31:0] csr_rdata,
    input  logic        exc_valid,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_tval,
    input  logic [31:0] exc_pc,
    input  logic        irq_ack,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    output logic        irq_pending,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 5;
    localparam logic [XLEN-1:0] IRQ_MASK = 32'h0000_0888;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRAP = 2'd1,
        RET  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic              mstatus_mie_q, mstatus_mpie_q;
    logic [XLEN-1:0]   mie_q, mip_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic              trap_irq_q;
    logic [CODE_W-1:0] trap_code_q;

    logic [XLEN-1:0]   mstatus_rd_c, old_c, operand_c, wdata_c, pending_c, trap_base_c;
    logic [CODE_W-1:0] irq_code_c;
    logic              take_exc_c, take_irq_c, take_ret_c, do_write_c;

    // MPP is hardwired to machine mode
    assign mstatus_rd_c = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};

    always_comb begin
        old_c = '0;
        case (csr_req.csr_target)
            CSR_MSTATUS:  old_c = mstatus_rd_c;
            CSR_MIE:      old_c = mie_q;
            CSR_MTVEC:    old_c = mtvec_q;
            CSR_MSCRATCH: old_c = mscratch_q;
            CSR_MEPC:     old_c = mepc_q;
            CSR_MCAUSE:   old_c = mcause_q;
            CSR_MTVAL:    old_c = mtval_q;
            CSR_MIP:      old_c = mip_q;
            CSR_MHARTID:  old_c = HART_ID;
            default:      old_c = '0;
        endcase
    end

    assign csr_rdata = csr_req.valid ? old_c : '0;
    assign operand_c = csr_req.use_imm ? XLEN'(zimm) : rs1_data;

    always_comb begin
        wdata_c = operand_c;
        case (csr_req.csr_mode)
            CSR_RS:  wdata_c = old_c | operand_c;
            CSR_RC:  wdata_c = old_c & ~operand_c;
            default: wdata_c = operand_c;
        endcase
    end

    // Interrupt selection: external > software > timer
    assign pending_c   = mie_q & mip_q;
    assign irq_pending = mstatus_mie_q & (|pending_c);
    always_comb begin
        irq_code_c = CODE_W'(7);
        if (pending_c[11])     irq_code_c = CODE_W'(11);
        else if (pending_c[3]) irq_code_c = CODE_W'(3);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        take_exc_c = 1'b0;
        take_irq_c = 1'b0;
        take_ret_c = 1'b0;
        do_write_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    take_exc_c = 1'b1;
                    state_d    = TRAP;
                end else if (irq_ack && irq_pending) begin
                    take_irq_c = 1'b1;
                    state_d    = TRAP;
                end else if (mret) begin
                    take_ret_c = 1'b1;
                    state_d    = RET;
                end else begin
                    do_write_c = csr_req.valid && (csr_req.csr_mode != CSR_READ);
                end
            end
            TRAP:    state_d = IDLE;
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign trap_base_c = {mtvec_q[31:2], 2'b00};

    // Redirect is suppressed in the cycle reset is applied
    always_comb begin
        busy           = (state_q != IDLE);
        redirect_valid = (state_q != IDLE) && !rst;
        redirect_pc    = '0;
        if (state_q == TRAP) begin
            redirect_pc = trap_base_c;
            if (trap_irq_q && (mtvec_q[1:0] == 2'b01))
                redirect_pc = trap_base_c + (XLEN'(trap_code_q) << 2);
        end else if (state_q == RET) begin
            redirect_pc = mepc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            trap_irq_q     <= 1'b0;
            trap_code_q    <= '0;
        end else begin
            mip_q <= {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_sw, 3'd0};
            if (take_exc_c || take_irq_c) begin
                mepc_q         <= {exc_pc[31:2], 2'b00};
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
                mcause_q       <= take_exc_c ? exc_cause : {1'b1, 26'd0, irq_code_c};
                mtval_q        <= take_exc_c ? exc_tval : '0;
                trap_irq_q     <= take_irq_c;
                trap_code_q    <= irq_code_c;
            end else if (take_ret_c) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (do_write_c) begin
                case (csr_req.csr_target)
                    CSR_MSTATUS: begin
                        mstatus_mie_q  <= wdata_c[3];
                        mstatus_mpie_q <= wdata_c[7];
                    end
                    CSR_MIE:      mie_q      <= wdata_c & IRQ_MASK;
                    CSR_MTVEC:    mtvec_q    <= {wdata_c[31:2], wdata_c[1] ? 2'b00 : wdata_c[1:0]};
                    CSR_MSCRATCH: mscratch_q <= wdata_c;
                    CSR_MEPC:     mepc_q     <= {wdata_c[31:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= wdata_c;
                    CSR_MTVAL:    mtval_q    <= wdata_c;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed and randomized checks of csr_unit against an architectural CSR model.
module tb_csr_unit;
    import csr_unit_pkg::*;

    localparam logic [31:0] HART  = 32'h0000_0005;
    localparam logic [31:0] MTVR  = 32'h0000_0080;

    logic        clk, rst;
    csr_req_t    csr_req;
    logic [31:0] rs1_data, csr_rdata, exc_cause, exc_tval, exc_pc, redirect_pc;
    logic [4:0]  zimm;
    logic        exc_valid, irq_ack, mret, irq_ext, irq_timer, irq_sw;
    logic        irq_pending, busy, redirect_valid;

    csr_unit #(.HART_ID(HART), .MTVEC_RESET(MTVR)) dut (
        .clk(clk), .rst(rst), .csr_req(csr_req), .rs1_data(rs1_data), .zimm(zimm),
        .csr_rdata(csr_rdata), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_tval(exc_tval), .exc_pc(exc_pc), .irq_ack(irq_ack), .mret(mret),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
        .irq_pending(irq_pending), .busy(busy), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Architectural model state
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_r, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

    function automatic logic [31:0] mread(input logic [11:0] a);
        case (a)
            CSR_MSTATUS:  return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            CSR_MIE:      return m_mie_r;
            CSR_MTVEC:    return m_mtvec;
            CSR_MSCRATCH: return m_mscratch;
            CSR_MEPC:     return m_mepc;
            CSR_MCAUSE:   return m_mcause;
            CSR_MTVAL:    return m_mtval;
            CSR_MIP:      return m_mip;
            CSR_MHARTID:  return HART;
            default:      return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_mie_r = 0; m_mip = 0; m_mtvec = MTVR;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    endtask

    task automatic model_write(input csr_mode_e m, input logic [11:0] a, input logic [31:0] op);
        logic [31:0] nv;
        if (m == CSR_READ) return;
        nv = (m == CSR_RW) ? op : (m == CSR_RS) ? (mread(a) | op) : (mread(a) & ~op);
        case (a)
            CSR_MSTATUS:  begin m_mie = nv[3]; m_mpie = nv[7]; end
            CSR_MIE:      m_mie_r = nv & 32'h888;
            CSR_MTVEC:    m_mtvec = (nv[1:0] >= 2'd2) ? (nv & ~32'd3) : nv;
            CSR_MSCRATCH: m_mscratch = nv;
            CSR_MEPC:     m_mepc = nv & ~32'd3;
            CSR_MCAUSE:   m_mcause = nv;
            CSR_MTVAL:    m_mtval = nv;
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        csr_req = '0; rs1_data = 0; zimm = 0;
        exc_valid = 0; exc_cause = 0; exc_tval = 0; exc_pc = 0;
        irq_ack = 0; mret = 0;
    endtask

    task automatic csr_op(input csr_mode_e m, input bit imm, input logic [11:0] a,
                          input logic [31:0] opnd);
        @(negedge clk);
        set_idle();
        csr_req.valid = 1'b1; csr_req.use_imm = imm; csr_req.csr_mode = m; csr_req.csr_target = a;
        rs1_data = imm ? ~opnd : opnd;
        zimm = opnd[4:0];
        #1;
        check($sformatf("rdata_%h", a), csr_rdata, mread(a));
        model_write(m, a, imm ? {27'd0, opnd[4:0]} : opnd);
    endtask

    task automatic csr_read(input logic [11:0] a);
        csr_op(CSR_READ, 1'b0, a, $urandom);
    endtask

    // One redirect cycle, then back to idle
    task automatic redirect_check(input string tag, input logic [31:0] exp_pc);
        @(negedge clk);
        set_idle();
        #1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_rv"}, 32'(redirect_valid), 32'd1);
        check({tag, "_pc"}, redirect_pc, exp_pc);
        @(negedge clk);
        #1;
        check({tag, "_rv_end"}, 32'(redirect_valid), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic do_exc(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                          input bit with_mret, input bit with_write);
        @(negedge clk);
        set_idle();
        exc_valid = 1; exc_cause = cause; exc_pc = pc; exc_tval = tval; mret = with_mret;
        if (with_write) begin
            csr_req.valid = 1'b1; csr_req.csr_mode = CSR_RW; csr_req.csr_target = CSR_MSCRATCH;
            rs1_data = $urandom;
        end
        m_mpie = m_mie; m_mie = 0; m_mepc = pc & ~32'd3; m_mcause = cause; m_mtval = tval;
        redirect_check("exc", m_mtvec & ~32'd3);
    endtask

    task automatic do_irq(input logic [31:0] pc);
        logic [31:0] pend, code, tgt;
        @(negedge clk);
        set_idle();
        irq_ack = 1; exc_pc = pc;
        pend = m_mie_r & m_mip;
        code = pend[11] ? 32'd11 : pend[3] ? 32'd3 : 32'd7;
        tgt  = (m_mtvec & ~32'd3) + ((m_mtvec[1:0] == 2'b01) ? 4 * code : 0);
        m_mpie = m_mie; m_mie = 0; m_mepc = pc & ~32'd3;
        m_mcause = 32'h8000_0000 | code; m_mtval = 0;
        redirect_check("irq", tgt);
    endtask

    task automatic do_mret();
        @(negedge clk);
        set_idle();
        mret = 1;
        m_mie = m_mpie; m_mpie = 1;
        redirect_check("mret", m_mepc);
    endtask

    task automatic set_irq_lines(input bit e, input bit t, input bit s);
        @(negedge clk);
        irq_ext = e; irq_timer = t; irq_sw = s;
        @(negedge clk);
        m_mip = (32'(e) << 11) | (32'(t) << 7) | (32'(s) << 3);
        #1;
        check("irq_pending", 32'(irq_pending), 32'(m_mie && ((m_mie_r & m_mip) != 0)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [11:0] addrs [10];
    initial begin
        addrs = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
                  CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MHARTID, 12'h7C0};
        rst = 1; set_idle(); irq_ext = 0; irq_timer = 0; irq_sw = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check("rst_rv", 32'(redirect_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(irq_pending), 32'd0);
        check("rdata_novalid", csr_rdata, 32'd0);
        csr_read(CSR_MTVEC);
        csr_read(CSR_MHARTID);
        csr_read(CSR_MSTATUS);
        csr_read(CSR_MEPC);

        // Read-modify-write on mscratch, register and immediate forms
        csr_op(CSR_RW, 0, CSR_MSCRATCH, 32'hDEAD_BEEF);
        csr_op(CSR_RS, 0, CSR_MSCRATCH, 32'h0000_0011);
        csr_read(CSR_MSCRATCH);
        csr_op(CSR_RC, 1, CSR_MSCRATCH, 32'h0000_000F);
        csr_op(CSR_RS, 1, CSR_MSCRATCH, 32'h0000_0003);
        csr_read(CSR_MSCRATCH);
        csr_op(CSR_RW, 0, CSR_MTVEC, 32'h0000_0102);
        csr_read(CSR_MTVEC);
        csr_op(CSR_RW, 0, CSR_MEPC, 32'h0000_1237);
        csr_read(CSR_MEPC);
        csr_op(CSR_RW, 0, CSR_MHARTID, 32'hFFFF_FFFF);
        csr_read(CSR_MHARTID);

        // Direct-mode exception
        csr_op(CSR_RW, 0, CSR_MTVEC, 32'h0000_0100);
        csr_op(CSR_RS, 1, CSR_MSTATUS, 32'd8);
        do_exc(32'd2, 32'h40, 32'h1234, 0, 0);
        csr_read(CSR_MEPC);
        csr_read(CSR_MCAUSE);
        csr_read(CSR_MTVAL);
        csr_read(CSR_MSTATUS);

        // Vectored interrupts: external beats timer, software beats timer
        csr_op(CSR_RW, 0, CSR_MTVEC, 32'h0000_0201);
        csr_op(CSR_RW, 0, CSR_MIE, 32'hFFFF_FFFF);
        csr_op(CSR_RW, 0, CSR_MIE, 32'h0000_0888);
        csr_op(CSR_RS, 1, CSR_MSTATUS, 32'd8);
        set_irq_lines(1, 1, 0);
        csr_read(CSR_MIP);
        do_irq(32'h88);
        csr_read(CSR_MCAUSE);
        csr_read(CSR_MTVAL);
        csr_read(CSR_MSTATUS);
        set_irq_lines(0, 0, 0);
        do_mret();
        csr_read(CSR_MSTATUS);
        set_irq_lines(0, 1, 1);
        do_irq(32'h9C);
        csr_read(CSR_MCAUSE);
        set_irq_lines(0, 0, 0);
        do_mret();

        // Exception wins over mret and a same-cycle CSR write
        do_exc(32'd5, 32'h300, 32'd7, 1, 1);
        csr_read(CSR_MSCRATCH);
        csr_read(CSR_MSTATUS);
        csr_read(CSR_MEPC);

        // Reset while in TRAP
        @(negedge clk);
        set_idle();
        exc_valid = 1; exc_cause = 32'd4; exc_pc = 32'h500;
        @(negedge clk);
        set_idle();
        rst = 1;
        #1;
        check("rst_trap_rv", 32'(redirect_valid), 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        check("post_rst_rv", 32'(redirect_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        csr_read(CSR_MTVEC);
        csr_read(CSR_MSTATUS);
        csr_read(CSR_MSCRATCH);

        // Randomized accesses with occasional traps and returns
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0)
                do_exc($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
            else if ($urandom_range(0, 9) == 0)
                do_mret();
            else
                csr_op(csr_mode_e'($urandom_range(0, 3)), 1'($urandom), addrs[sel], $urandom);
        end
        for (int i = 0; i < 10; i++) csr_read(addrs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
